// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Counter must be able to hold the larger of the two intervals.
    function automatic int cnt_w(input int hold, input int gap);
        return clog2(((hold > gap) ? hold : gap) + 1);
    endfunction

    function automatic int idx_w(input int n);
        return clog2(n + 1);
    endfunction

endpackage

// File: rtl/rst_sync_bank.sv
// Per-bit multi-stage synchronizer for async reset requests; flushes to 1 on rst_i.
module rst_sync_bank #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff;

        always_ff @(posedge clk) begin
            if (rst_i) ff <= '1;
            else       ff <= {ff[STAGES-2:0], async_i[i]};
        end

        assign sync_o[i] = ff[STAGES-1];
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-source reset synchronizer and sequencer: holds all domains in reset,
// then releases them one at a time with a fixed gap, and records reset causes.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int NUM_OUT     = 3,
    parameter int STAGES      = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] async_rst_i,
    input  logic [NUM_SRC-1:0] src_mask_i,
    input  logic               cause_clr_i,
    output logic [NUM_OUT-1:0] rst_o,
    output logic               done_o,
    output logic [NUM_SRC-1:0] cause_o
);

    localparam int CNT_W = cnt_w(HOLD_CYCLES, GAP_CYCLES);
    localparam int IDX_W = idx_w(NUM_OUT);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [NUM_SRC-1:0] src_sync;
    logic [NUM_SRC-1:0] src_req;
    logic               req;

    rst_sync_bank #(
        .WIDTH  (NUM_SRC),
        .STAGES (STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_i   (rst_i),
        .async_i (async_rst_i),
        .sync_o  (src_sync)
    );

    assign src_req = src_sync & ~src_mask_i;
    assign req     = |src_req;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rst_o   <= '1;
            done_o  <= 1'b0;
            cause_o <= '0;
        end else begin
            // Set dominates clear so a still-active source is never lost.
            cause_o <= (cause_o & ~{NUM_SRC{cause_clr_i}}) | src_req;

            if (req) begin
                state  <= ASSERT;
                cnt    <= '0;
                idx    <= '0;
                rst_o  <= '1;
                done_o <= 1'b0;
            end else begin
                case (state)
                    ASSERT: begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt      <= '0;
                            idx      <= '0;
                            rst_o[0] <= 1'b0;
                            if (NUM_OUT == 1) begin
                                state  <= RUN;
                                done_o <= 1'b1;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            idx <= idx + 1'b1;
                            for (int i = 1; i < NUM_OUT; i++)
                                if (i == int'(idx) + 1) rst_o[i] <= 1'b0;
                            // Last domain released in this update.
                            if (int'(idx) + 2 == NUM_OUT) begin
                                state  <= RUN;
                                done_o <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: ;
                    default: state <= ASSERT;
                endcase
            end
        end
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Multi-source, multi-domain reset synchronizer and sequencer. It is the parametrised successor of the team's two-flop reset synchronizer.
- NUM_SRC asynchronous reset requests are synchronized to clk, masked, and OR-combined.
- Release of NUM_OUT reset outputs is sequenced: a minimum hold time first, then a fixed gap between domains.
- Provides a sticky reset-cause record. Sits at the top of each clock domain, ahead of the domain's functional logic.

Parameters:
- NUM_SRC, 2, number of asynchronous reset request inputs (>=1)
- NUM_OUT, 3, number of sequenced reset outputs (>=1)
- STAGES, 2, synchronizer depth per source (>=2)
- HOLD_CYCLES, 16, minimum cycles all outputs stay asserted after requests clear (>=1)
- GAP_CYCLES, 4, cycles between successive output releases (>=1)

Ports:
- clk  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high block reset
- async_rst_i  in  NUM_SRC  asynchronous reset requests, active-high, unrelated to clk
- src_mask_i  in  NUM_SRC  1 = ignore that source; quasi-static, synchronous to clk
- cause_clr_i  in  1  single-cycle pulse, clears cause_o
- rst_o  out  NUM_OUT  sequenced synchronous resets, active-high; bit 0 releases first
- done_o  out  1  high when all outputs are released (state RUN)
- cause_o  out  NUM_SRC  sticky record of unmasked sources that requested reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst_i).
- Synchronizer:
  - Each async_rst_i bit passes through STAGES flops carrying the ASYNC_REG attribute, giving src_sync.
  - On rst_i, all synchronizer flops load 1, so requests are treated as asserted until flushed.
- req = |(src_sync & ~src_mask_i), combinational from the synchronizer outputs.
- rst_i=1: state=ASSERT, counters=0, rst_o=all 1, done_o=0, cause_o=0. All outputs are registered.
- FSM states: ASSERT, HOLD, RELEASE, RUN.
  - ASSERT: rst_o all 1. Stay while req=1. req=0 -> HOLD with cnt=0.
  - HOLD: cnt increments each cycle. When cnt==HOLD_CYCLES-1 -> RELEASE, idx=0, cnt=0, and rst_o[0] cleared in the same update.
  - RELEASE: cnt increments. When cnt==GAP_CYCLES-1, clear rst_o[idx+1], increment idx, reset cnt.
  - When rst_o[NUM_OUT-1] clears, the next state is RUN and done_o is set in the same update.
  - If NUM_OUT==1, HOLD goes directly to RUN, with rst_o[0]=0 and done_o=1.
  - RUN: hold rst_o=0 and done_o=1 until req.
- req=1 in any state (highest priority after rst_i): the next cycle is ASSERT with rst_o all 1, done_o=0 and counters cleared. A new request mid-HOLD or mid-RELEASE restarts the full sequence.
- Timing: let T0 be the first cycle in ASSERT with req=0.
  - rst_o[k] is first low in cycle T0+1+HOLD_CYCLES+k*GAP_CYCLES.
  - done_o is first high in the same cycle as rst_o[NUM_OUT-1].
- Assertion latency: from async_rst_i rising (captured at a clock edge) to rst_o high is STAGES+1 cycles. This is synchronous assertion by design.
- Release order is strictly monotonic: rst_o[j]=0 implies rst_o[i]=0 for all i<j.
- rst_o never glitches. Every output is a flop Q.
- cause_o:
  - Each cycle, cause_o <= (cause_o & ~{NUM_SRC{cause_clr_i}}) | (src_sync & ~src_mask_i).
  - A set and a clear in the same cycle: set wins.
  - Masking a source clears neither its synchronizer nor its stored cause bit.
- Counter width: CNT_W = clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). idx width = clog2(NUM_OUT+1).
- Masking a source while its request is held immediately drops req and starts HOLD.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum {ASSERT, HOLD, RELEASE, RUN}
  - clog2 helper function
  - CNT_W/IDX_W derivation
- Sub-module rst_sync_bank (parameters WIDTH, STAGES): per-bit STAGES-deep synchronizer with ASYNC_REG and a synchronous set-to-1 on rst_i. It replaces and generalises the existing two-flop synchronizer.

Test Plan:
- Power-up, defaults:
  - Stimulus: rst_i high 5 cycles, async_rst_i=0, mask=0. rst_i low from cycle 0.
  - Response: req=0 at cycle 2. rst_o[0] low at cycle 19, rst_o[1] at 23, rst_o[2] at 27. done_o high at 27. cause_o=0.
- Request in RUN:
  - Stimulus: async_rst_i[1] high for 10 cycles.
  - Response: rst_o=3'b111 and done_o=0 exactly 3 cycles after capture. cause_o=2'b10. Release sequence restarts 17 cycles after the synchronized request drops.
- Request mid-RELEASE:
  - Stimulus: assert async_rst_i[0] 1 cycle after rst_o[0] falls.
  - Response: rst_o[0] reasserts, rst_o[2:1] stay 1. Full HOLD of 16 cycles repeats. Order stays monotonic.
- Mask:
  - Stimulus: src_mask_i=2'b01, async_rst_i[0] toggling.
  - Response: rst_o stays 0, done_o stays 1, cause_o[0] stays 0.
  - Then unmask while the input is held high: reset occurs and cause_o[0]=1.
- Cause clear:
  - Stimulus: cause_clr_i pulsed while src_sync[1]=1.
  - Response: cause_o[1] stays 1 (set wins). A pulse after the source drops clears it to 0.
- Parameter sweep:
  - Configurations: NUM_OUT=1, HOLD=1, GAP=1, STAGES=3.
  - Response: rst_o[0] low at cycle STAGES+2=5 after rst_i drops. done_o rises in the same cycle.
  - Random async pulses: rst_o never glitches and never reaches RUN while req=1.
